// File: rtl/game_state_ctrl.sv
// ---------------------------------------------------------------------------
// game_state_ctrl
//
// Top-level match sequencer for the ping-pong game. It keeps both players'
// scores, times the pause before each serve from the 1 ms tick, and drives
// game_state into the display mux. The ball is held at the centre whenever
// the match is not in live play.
//
// Parameters
//   WIN_SCORE  points needed to win, 1 .. (2**SCORE_W)-1
//   SERVE_MS   serve pause length in clk_1ms rising edges, >= 1
//   SCORE_W    width of each score counter
//
// Ports
//   clk          in   system (pixel) clock
//   reset        in   asynchronous reset, active low
//   clk_1ms      in   1 kHz square wave, asynchronous to clk
//   btn_start    in   debounced start/restart button level
//   miss_left    in   1-cycle pulse, ball passed the left paddle (player 1)
//   miss_right   in   1-cycle pulse, ball passed the right paddle (player 2)
//   game_state   out  00 idle, 01 play, 10 player-1 wins, 11 player-2 wins
//   ball_freeze  out  1 = ball held at centre
//   serve_dir    out  0 = serve toward left, 1 = serve toward right
//   score1       out  player-1 points
//   score2       out  player-2 points
// ---------------------------------------------------------------------------
module game_state_ctrl #(
  parameter int WIN_SCORE = 5,
  parameter int SERVE_MS  = 1000,
  parameter int SCORE_W   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clk_1ms,
  input  logic               btn_start,
  input  logic               miss_left,
  input  logic               miss_right,
  output logic [1:0]         game_state,
  output logic               ball_freeze,
  output logic               serve_dir,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2
);

  // Serve counter only has to reach SERVE_MS-1; keep at least one bit.
  localparam int MS_W = (SERVE_MS > 1) ? $clog2(SERVE_MS) : 1;
  localparam logic [MS_W-1:0]    MS_LAST  = MS_W'(SERVE_MS - 1);
  // Comparing against WIN_SCORE-1 before incrementing means the win is
  // detected without the counter ever having to hold a wrapped value.
  localparam logic [SCORE_W-1:0] WIN_LAST = SCORE_W'(WIN_SCORE - 1);

  localparam logic [1:0] GS_IDLE  = 2'b00;
  localparam logic [1:0] GS_PLAY  = 2'b01;
  localparam logic [1:0] GS_P1WIN = 2'b10;
  localparam logic [1:0] GS_P2WIN = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_P1WIN = 3'd3,
    ST_P2WIN = 3'd4
  } state_t;

  state_t state_q;
  state_t state_next;

  logic            ms_sync1;
  logic            ms_sync2;
  logic            ms_prev;
  logic            tick_ms;
  logic            btn_prev;
  logic            start_p;
  logic [MS_W-1:0] ms_cnt;

  logic            miss_left_only;
  logic            miss_right_only;
  logic            miss_both;
  logic            serve_done;
  logic            p1_wins;
  logic            p2_wins;

  logic [1:0]      game_state_next;
  logic            ball_freeze_next;

  // clk_1ms crosses into the clk domain through two flops; a third flop
  // remembers the previous synchronised level so a registered rising-edge
  // pulse can be formed. The registered pulse lands three clk cycles after
  // clk_1ms rises.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ms_sync1 <= 1'b0;
      ms_sync2 <= 1'b0;
      ms_prev  <= 1'b0;
      tick_ms  <= 1'b0;
    end else begin
      ms_sync1 <= clk_1ms;
      ms_sync2 <= ms_sync1;
      ms_prev  <= ms_sync2;
      tick_ms  <= ms_sync2 & ~ms_prev;
    end
  end

  // The button is already debounced and synchronous, so a single history
  // flop is enough for a rise detect. Because btn_prev clears on reset, a
  // button held through reset release starts exactly one game.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_prev <= 1'b0;
    end else begin
      btn_prev <= btn_start;
    end
  end

  // Event decode shared by the next-state logic and the datapath, so both
  // always agree on what happened this cycle.
  always_comb begin
    start_p         = btn_start & ~btn_prev;
    miss_left_only  = miss_left & ~miss_right;
    miss_right_only = miss_right & ~miss_left;
    miss_both       = miss_left & miss_right;
    serve_done      = tick_ms && (ms_cnt == MS_LAST);
    p1_wins         = (score1 == WIN_LAST);
    p2_wins         = (score2 == WIN_LAST);
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_next;
    end
  end

  // Next-state logic. Misses only matter in live play; a miss by the left
  // player scores for player 2 and vice versa. Simultaneous misses are a
  // void rally. Any unused encoding falls back to IDLE.
  always_comb begin
    state_next = state_q;
    case (state_q)
      ST_IDLE, ST_P1WIN, ST_P2WIN: begin
        if (start_p) begin
          state_next = ST_SERVE;
        end
      end
      ST_SERVE: begin
        if (serve_done) begin
          state_next = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (miss_both) begin
          state_next = ST_SERVE;
        end else if (miss_left_only) begin
          state_next = p2_wins ? ST_P2WIN : ST_SERVE;
        end else if (miss_right_only) begin
          state_next = p1_wins ? ST_P1WIN : ST_SERVE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state, so the registered outputs change
  // on the same edge as the state register rather than one cycle later.
  always_comb begin
    game_state_next  = GS_IDLE;
    ball_freeze_next = 1'b1;
    case (state_next)
      ST_IDLE: begin
        game_state_next  = GS_IDLE;
        ball_freeze_next = 1'b1;
      end
      ST_SERVE: begin
        game_state_next  = GS_PLAY;
        ball_freeze_next = 1'b1;
      end
      ST_PLAY: begin
        game_state_next  = GS_PLAY;
        ball_freeze_next = 1'b0;
      end
      ST_P1WIN: begin
        game_state_next  = GS_P1WIN;
        ball_freeze_next = 1'b1;
      end
      ST_P2WIN: begin
        game_state_next  = GS_P2WIN;
        ball_freeze_next = 1'b1;
      end
      default: begin
        game_state_next  = GS_IDLE;
        ball_freeze_next = 1'b1;
      end
    endcase
  end

  // Registered display outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      game_state  <= GS_IDLE;
      ball_freeze <= 1'b1;
    end else begin
      game_state  <= game_state_next;
      ball_freeze <= ball_freeze_next;
    end
  end

  // Match datapath: serve timer, scores and serve direction. The serve goes
  // toward the player who just lost the point; a void rally just swaps the
  // side. Scores are frozen on the win screens until a restart clears them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ms_cnt    <= '0;
      score1    <= '0;
      score2    <= '0;
      serve_dir <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE, ST_P1WIN, ST_P2WIN: begin
          if (start_p) begin
            score1 <= '0;
            score2 <= '0;
            ms_cnt <= '0;
          end
        end
        ST_SERVE: begin
          if (tick_ms) begin
            ms_cnt <= serve_done ? '0 : ms_cnt + 1'b1;
          end
        end
        ST_PLAY: begin
          if (miss_both) begin
            serve_dir <= ~serve_dir;
          end else if (miss_left_only) begin
            score2    <= score2 + 1'b1;
            serve_dir <= 1'b0;
          end else if (miss_right_only) begin
            score1    <= score1 + 1'b1;
            serve_dir <= 1'b1;
          end
        end
        default: begin
          ms_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_state_ctrl.sv
// ---------------------------------------------------------------------------
// tb_game_state_ctrl
//
// Directed bench for game_state_ctrl with SERVE_MS=3 and WIN_SCORE=2.
// A table of one-cycle vectors covers start, the serve pause, scoring and a
// void rally; hand-written sequences cover asynchronous reset mid-serve,
// a button held through reset, and both win screens.
// Inputs change 1 ns after a rising clk edge and outputs are checked there.
// ---------------------------------------------------------------------------
module tb_game_state_ctrl;

  logic       clk;
  logic       reset;
  logic       clk_1ms;
  logic       btn_start;
  logic       miss_left;
  logic       miss_right;
  logic [1:0] game_state;
  logic       ball_freeze;
  logic       serve_dir;
  logic [3:0] score1;
  logic [3:0] score2;

  int vec_count   = 0;
  int miscompares = 0;

  typedef struct {
    logic       btn;
    logic       ml;
    logic       mr;
    logic       ms;
    logic [1:0] gs;
    logic       frz;
    logic       dir;
    logic [3:0] s1;
    logic [3:0] s2;
  } vec_t;

  vec_t vecs[$];

  game_state_ctrl #(
    .WIN_SCORE(2),
    .SERVE_MS (3),
    .SCORE_W  (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .clk_1ms    (clk_1ms),
    .btn_start  (btn_start),
    .miss_left  (miss_left),
    .miss_right (miss_right),
    .game_state (game_state),
    .ball_freeze(ball_freeze),
    .serve_dir  (serve_dir),
    .score1     (score1),
    .score2     (score2)
  );

  // 100 MHz-style free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Guard against a hung run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic addVec(input logic b, input logic ml, input logic mr, input logic ms,
                        input logic [1:0] gs, input logic frz, input logic dir,
                        input logic [3:0] s1, input logic [3:0] s2);
    vec_t v;
    v.btn = b;  v.ml = ml; v.mr = mr; v.ms = ms;
    v.gs  = gs; v.frz = frz; v.dir = dir; v.s1 = s1; v.s2 = s2;
    vecs.push_back(v);
  endtask

  // Drive one cycle of inputs and step past the next rising edge.
  task automatic applyStimulus(input logic b, input logic ml, input logic mr, input logic ms);
    btn_start  = b;
    miss_left  = ml;
    miss_right = mr;
    clk_1ms    = ms;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [1:0] gs, input logic frz,
                             input logic dir, input logic [3:0] s1, input logic [3:0] s2);
    logic [10:0] act;
    logic [10:0] exp;
    act = {game_state, ball_freeze, serve_dir, score1, score2};
    exp = {gs, frz, dir, s1, s2};
    vec_count++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got gs=%b frz=%b dir=%b s1=%0d s2=%0d, want gs=%b frz=%b dir=%b s1=%0d s2=%0d",
               tag, game_state, ball_freeze, serve_dir, score1, score2, gs, frz, dir, s1, s2);
    end
  endtask

  // Three clk_1ms pulses from SERVE with a cleared counter: the third tick
  // reaches the FSM on the eighth edge, so freeze must hold for seven
  // cycles and drop on the eighth. Needs clk_1ms low for the prior 3 cycles.
  task automatic serveWait(input string tag, input logic b, input logic dir,
                           input logic [3:0] s1, input logic [3:0] s2);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(b, 1'b0, 1'b0, (i < 6) && (i % 2 == 0));
      checkOutput(tag, 2'b01, (i == 7) ? 1'b0 : 1'b1, dir, s1, s2);
    end
  endtask

  initial begin
    // Vector table: btn ml mr ms | gs frz dir s1 s2
    addVec(0,0,0,0, 2'b00,1,1,0,0);   // idle, nothing pressed
    addVec(1,0,0,0, 2'b01,1,1,0,0);   // start -> serve
    addVec(0,0,0,1, 2'b01,1,1,0,0);
    addVec(0,1,0,0, 2'b01,1,1,0,0);   // miss ignored in serve
    addVec(0,0,0,1, 2'b01,1,1,0,0);
    addVec(0,0,0,0, 2'b01,1,1,0,0);   // tick 1
    addVec(0,0,0,1, 2'b01,1,1,0,0);
    addVec(0,0,1,0, 2'b01,1,1,0,0);   // tick 2, miss ignored
    addVec(0,0,0,0, 2'b01,1,1,0,0);
    addVec(0,0,0,0, 2'b01,0,1,0,0);   // tick 3 -> play
    addVec(0,1,0,0, 2'b01,1,0,0,1);   // left miss: P2 scores, serve left
    addVec(0,0,0,1, 2'b01,1,0,0,1);
    addVec(0,0,0,0, 2'b01,1,0,0,1);
    addVec(0,0,0,1, 2'b01,1,0,0,1);
    addVec(0,0,0,0, 2'b01,1,0,0,1);
    addVec(0,0,0,1, 2'b01,1,0,0,1);
    addVec(0,0,0,0, 2'b01,1,0,0,1);
    addVec(0,0,0,0, 2'b01,1,0,0,1);
    addVec(0,0,0,0, 2'b01,0,0,0,1);   // back to play
    addVec(0,1,1,0, 2'b01,1,1,0,1);   // void rally: dir toggles
    addVec(0,0,0,1, 2'b01,1,1,0,1);
    addVec(0,0,0,0, 2'b01,1,1,0,1);
    addVec(0,0,0,1, 2'b01,1,1,0,1);
    addVec(0,0,0,0, 2'b01,1,1,0,1);
    addVec(0,0,0,1, 2'b01,1,1,0,1);
    addVec(0,0,0,0, 2'b01,1,1,0,1);
    addVec(0,0,0,0, 2'b01,1,1,0,1);
    addVec(0,0,0,0, 2'b01,0,1,0,1);   // play
    addVec(0,0,1,0, 2'b01,1,1,1,1);   // right miss: P1 scores, serve right

    reset      = 1'b0;
    btn_start  = 1'b0;
    miss_left  = 1'b0;
    miss_right = 1'b0;
    clk_1ms    = 1'b0;

    #12;
    checkOutput("reset_hold", 2'b00, 1'b1, 1'b1, 4'd0, 4'd0);
    #10;
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("reset_release", 2'b00, 1'b1, 1'b1, 4'd0, 4'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].btn, vecs[i].ml, vecs[i].mr, vecs[i].ms);
      checkOutput($sformatf("vec%0d", i), vecs[i].gs, vecs[i].frz, vecs[i].dir,
                  vecs[i].s1, vecs[i].s2);
    end

    // Two ticks into the serve (counter at 2), then asynchronous reset.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, (i < 4) && (i % 2 == 0));
      checkOutput("serve_cnt2", 2'b01, 1'b1, 1'b1, 4'd1, 4'd1);
    end
    #2;
    reset     = 1'b0;
    btn_start = 1'b1;
    #1;
    checkOutput("reset_async", 2'b00, 1'b1, 1'b1, 4'd0, 4'd0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("reset_held_btn", 2'b00, 1'b1, 1'b1, 4'd0, 4'd0);
    end

    // Release reset with the button still held: exactly one start.
    reset = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("held_start", 2'b01, 1'b1, 1'b1, 4'd0, 4'd0);
    serveWait("serve_after_reset", 1'b1, 1'b1, 4'd0, 4'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("p1_point1", 2'b01, 1'b1, 1'b1, 4'd1, 4'd0);
    serveWait("serve_p1_1", 1'b1, 1'b1, 4'd1, 4'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("p1_win", 2'b10, 1'b1, 1'b1, 4'd2, 4'd0);

    // Win screen: misses, ticks and the still-held button change nothing.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("p1win_hold_a", 2'b10, 1'b1, 1'b1, 4'd2, 4'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("p1win_hold_b", 2'b10, 1'b1, 1'b1, 4'd2, 4'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("p1win_hold_c", 2'b10, 1'b1, 1'b1, 4'd2, 4'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("p1win_release", 2'b10, 1'b1, 1'b1, 4'd2, 4'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("restart", 2'b01, 1'b1, 1'b1, 4'd0, 4'd0);

    // Player 2 takes the next game.
    serveWait("serve_restart", 1'b0, 1'b1, 4'd0, 4'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("p2_point1", 2'b01, 1'b1, 1'b0, 4'd0, 4'd1);
    serveWait("serve_p2_1", 1'b0, 1'b0, 4'd0, 4'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("p2_win", 2'b11, 1'b1, 1'b0, 4'd0, 4'd2);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("p2win_hold", 2'b11, 1'b1, 1'b0, 4'd0, 4'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
